ir_packet_decoder: RTL and testbench

IR_PACKET_DECODER -- requirements
Module: ir_packet_decoder

---
 rtl/ir_packet_decoder.sv | 179 +++++++++++++++++
 tb/tb_ir_packet_decoder.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ir_packet_decoder.sv
// IR remote frame decoder: start burst, car-select burst, then four data bursts whose
// lengths encode the command bits. Malformed or timed-out frames pulse frame_error.
module ir_packet_decoder #(
    parameter int unsigned CNT_W       = 20,
    parameter int unsigned START_MIN   = 150000,
    parameter int unsigned SELECT_MIN  = 40000,
    parameter int unsigned BIT0_MIN    = 20000,
    parameter int unsigned BIT1_MIN    = 60000,
    parameter int unsigned GAP_TIMEOUT = 100000
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       ir_in,
    output logic [3:0] command,
    output logic       cmd_valid,
    output logic       frame_error,
    output logic       busy
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StSelGap,
        StSelect,
        StDataGap,
        StData
    } state_e;

    localparam logic [CNT_W-1:0] CntMax     = '1;
    localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
    localparam logic [CNT_W-1:0] StartMin   = CNT_W'(START_MIN);
    localparam logic [CNT_W-1:0] SelectMin  = CNT_W'(SELECT_MIN);
    localparam logic [CNT_W-1:0] Bit0Min    = CNT_W'(BIT0_MIN);
    localparam logic [CNT_W-1:0] Bit1Min    = CNT_W'(BIT1_MIN);
    localparam logic [CNT_W-1:0] GapTimeout = CNT_W'(GAP_TIMEOUT);

    state_e           state_q, state_d;
    logic [2:0]       sync_q;
    logic [1:0]       prime_q;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       bits_q, bits_d;
    logic [1:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       command_q, command_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             frame_error_q, frame_error_d;

    logic rise, fall;
    logic len_start, len_select, len_bit0, len_bit1, gap_expired;

    // sync_q[1] is the synchronised input; sync_q[2] is its one-cycle delayed copy
    assign rise = sync_q[1] & ~sync_q[2];
    assign fall = ~sync_q[1] & sync_q[2];

    // cnt_inc equals the length of the level that ends on an edge this cycle
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
    assign cnt_d   = (rise || fall) ? '0 : cnt_inc;

    assign len_start   = (cnt_inc >= StartMin);
    assign len_select  = (cnt_inc >= SelectMin);
    assign len_bit0    = (cnt_inc >= Bit0Min);
    assign len_bit1    = (cnt_inc >= Bit1Min);
    assign gap_expired = (cnt_inc >= GapTimeout);

    // A burst already in progress when reset releases must not look like a short start,
    // so a start is only accepted once the primed synchroniser has seen the line low.
    assign armed_d = armed_q | (prime_q[1] & ~sync_q[1]);

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rise && armed_q) state_d = StStart;
            end
            StStart: begin
                if (fall) state_d = len_start ? StSelGap : StIdle;
            end
            StSelGap: begin
                if (gap_expired)  state_d = StIdle;
                else if (rise)    state_d = StSelect;
            end
            StSelect: begin
                if (fall) begin
                    if (len_start)       state_d = StSelGap;
                    else if (len_select) state_d = StDataGap;
                    else                 state_d = StIdle;
                end
            end
            StDataGap: begin
                if (gap_expired)  state_d = StIdle;
                else if (rise)    state_d = StData;
            end
            StData: begin
                if (fall) begin
                    if (len_start)              state_d = StSelGap;
                    else if (!len_bit0)         state_d = StIdle;
                    else if (bit_idx_q == 2'd3) state_d = StIdle;
                    else                        state_d = StDataGap;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_error_d = 1'b0;
        cmd_valid_d   = 1'b0;
        command_d     = command_q;
        bits_d        = bits_q;
        bit_idx_d     = bit_idx_q;
        unique case (state_q)
            StStart: begin
                if (fall && !len_start) frame_error_d = 1'b1;
            end
            StSelGap, StDataGap: begin
                if (gap_expired) frame_error_d = 1'b1;
            end
            StSelect: begin
                if (fall) begin
                    if (!len_start && len_select) bit_idx_d = 2'd0;
                    else                          frame_error_d = 1'b1;
                end
            end
            StData: begin
                if (fall) begin
                    if (len_start || !len_bit0) begin
                        frame_error_d = 1'b1;
                    end else if (bit_idx_q == 2'd3) begin
                        command_d   = {len_bit1, bits_q[2:0]};
                        cmd_valid_d = 1'b1;
                        bit_idx_d   = 2'd0;
                    end else begin
                        bits_d[bit_idx_q] = len_bit1;
                        bit_idx_d         = bit_idx_q + 2'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync_q        <= 3'b000;
            prime_q       <= 2'b00;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            bits_q        <= 4'b0000;
            bit_idx_q     <= 2'd0;
            command_q     <= 4'b0000;
            cmd_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[1:0], ir_in};
            prime_q       <= {prime_q[0], 1'b1};
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            bits_q        <= bits_d;
            bit_idx_q     <= bit_idx_d;
            command_q     <= command_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign command     = command_q;
    assign cmd_valid   = cmd_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_ir_packet_decoder.sv
// Directed bench for ir_packet_decoder with shortened timing parameters.
module tb_ir_packet_decoder;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b1;
    logic       ir_in   = 1'b0;
    logic [3:0] command;
    logic       cmd_valid;
    logic       frame_error;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_valid = 0;
    int n_err   = 0;
    int n_both  = 0;
    int last_err_cyc = 0;
    int drop_cyc     = 0;
    int v0, e0;

    ir_packet_decoder #(
        .CNT_W       (8),
        .START_MIN   (40),
        .SELECT_MIN  (20),
        .BIT0_MIN    (5),
        .BIT1_MIN    (12),
        .GAP_TIMEOUT (30)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .ir_in       (ir_in),
        .command     (command),
        .cmd_valid   (cmd_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(negedge sys_clk);
        cyc++;
        if (cmd_valid) n_valid++;
        if (frame_error) begin
            n_err++;
            last_err_cyc = cyc;
        end
        if (cmd_valid && frame_error) n_both++;
    endtask

    task automatic burst(input int hi, input int lo);
        ir_in = 1'b1;
        repeat (hi) tick();
        ir_in = 1'b0;
        drop_cyc = cyc;
        repeat (lo) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (3) tick();
        check("reset_command", 32'(command), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pulses", 32'({cmd_valid, frame_error}), 32'd0);
        reset = 1'b0;
        repeat (10) tick();

        // Valid frame 1,0,0,1
        v0 = n_valid; e0 = n_err;
        burst(45, 10);
        burst(25, 10);
        check("busy_mid_frame", 32'(busy), 32'd1);
        burst(15, 10); burst(6, 10); burst(6, 10); burst(15, 10);
        check("f1_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("f1_err_cnt", 32'(n_err - e0), 32'd0);
        check("f1_command", 32'(command), 32'b1001);
        check("f1_busy_after", 32'(busy), 32'd0);

        // Short start burst
        v0 = n_valid; e0 = n_err;
        burst(30, 40);
        check("short_start_err", 32'(n_err - e0), 32'd1);
        check("short_start_valid", 32'(n_valid - v0), 32'd0);
        check("short_start_busy", 32'(busy), 32'd0);
        check("short_start_cmd", 32'(command), 32'b1001);

        // Gap timeout after two data bits
        v0 = n_valid; e0 = n_err;
        burst(45, 10); burst(25, 10); burst(15, 10); burst(6, 35);
        check("timeout_err", 32'(n_err - e0), 32'd1);
        check("timeout_valid", 32'(n_valid - v0), 32'd0);
        check("timeout_latency", 32'(last_err_cyc - drop_cyc), 32'd33);
        check("timeout_busy", 32'(busy), 32'd0);
        check("timeout_cmd", 32'(command), 32'b1001);
        repeat (10) tick();

        // Saturating start, threshold-exact data bits 12,11,12,11
        v0 = n_valid; e0 = n_err;
        burst(300, 10); burst(25, 10);
        burst(12, 10); burst(11, 10); burst(12, 10); burst(11, 10);
        check("sat_valid", 32'(n_valid - v0), 32'd1);
        check("sat_err", 32'(n_err - e0), 32'd0);
        check("threshold_command", 32'(command), 32'b0101);

        // Data burst below BIT0_MIN
        v0 = n_valid; e0 = n_err;
        burst(45, 10); burst(25, 10); burst(4, 40);
        check("short_bit_err", 32'(n_err - e0), 32'd1);
        check("short_bit_valid", 32'(n_valid - v0), 32'd0);
        check("short_bit_cmd", 32'(command), 32'b0101);
        check("short_bit_busy", 32'(busy), 32'd0);

        // Long burst in SELECT acts as a new start
        v0 = n_valid; e0 = n_err;
        burst(45, 10); burst(45, 10);
        check("restart_err", 32'(n_err - e0), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        burst(25, 10); burst(15, 10); burst(15, 10); burst(6, 10); burst(6, 10);
        check("restart_valid", 32'(n_valid - v0), 32'd1);
        check("restart_err_total", 32'(n_err - e0), 32'd1);
        check("restart_command", 32'(command), 32'b0011);

        // Reset during third data burst, then frame 0,1,1,0
        v0 = n_valid; e0 = n_err;
        burst(45, 10); burst(25, 10); burst(15, 10); burst(6, 10);
        ir_in = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("midreset_command", 32'(command), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) tick();
        ir_in = 1'b0;
        repeat (20) tick();
        check("postreset_err", 32'(n_err - e0), 32'd0);
        check("postreset_busy", 32'(busy), 32'd0);
        burst(45, 10); burst(25, 10);
        burst(6, 10); burst(15, 10); burst(15, 10); burst(6, 10);
        check("reset_frame_valid", 32'(n_valid - v0), 32'd1);
        check("reset_frame_err", 32'(n_err - e0), 32'd0);
        check("reset_frame_command", 32'(command), 32'b0110);
        check("reset_frame_busy", 32'(busy), 32'd0);

        check("never_both_pulses", 32'(n_both), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
